area_weight_gen: RTL
====================

# area_weight_gen

Parametrised successor to the four-product area generator in the image scaling datapath. Takes the four distances (top, bottom, left, right) of a target pixel to its source neighbours and produces the four bilinear area weights plus their sum. Products are full precision with no truncation. Input and output use valid/ready handshakes. A build-time mode selects four parallel multipliers (low latency) or one time-shared multiplier (low area). Sits between the coordinate/distance generator and the interpolation MAC stage.

## Interface
- DW, 8: width of each distance input.
- PARALLEL, 1: 1 selects four multipliers (one compute cycle); 0 selects one shared multiplier (four compute cycles).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- top, bottom, left, right  in  DW each  unsigned distances, sampled on an input handshake.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands.
- a_mn  out  2*DW  left*top.
- a_m1n  out  2*DW  top*right.
- a_m1n1  out  2*DW  right*bottom.
- a_mn1  out  2*DW  bottom*left.
- w_sum  out  2*DW+2  a_mn+a_m1n+a_m1n1+a_mn1, exact.
- out_valid  out  1  weights valid and held.
- out_ready  in  1  downstream accepts the weights.

## Operation
- The FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - An input handshake occurs when in_valid&&in_ready at a clock edge. It registers the four distances, clears the step counter to 0, and moves to CALC.
- CALC
  - in_ready=0.
  - PARALLEL=1: all four products and w_sum are registered at the next edge. Then go to DONE.
  - PARALLEL=0: a 2-bit step counter selects the operand pair. Step 0 is left*top, 1 is top*right, 2 is right*bottom, 3 is bottom*left.
  - Each edge registers one product into its output register and adds it to a w_sum accumulator. The accumulator is cleared on the input handshake.
  - After step 3, go to DONE.
- DONE
  - out_valid=1, in_ready=0.
  - All outputs stay stable until an output handshake (out_valid&&out_ready at an edge), then go to IDLE.
  - Output registers keep their last values after leaving DONE; only out_valid drops.
- Arithmetic is unsigned.
  - Each product is exact in 2*DW bits.
  - w_sum is exact in 2*DW+2 bits, so no overflow at all-ones inputs.
- Operand registers are loaded only on the input handshake. Input pins are ignored at all other times.
- in_valid may be held high while the block is busy. It is accepted only in IDLE.
- No internal abort exists. Reset is the only way to cancel a computation in progress.

## Timing
- Reset values: in_ready=1, out_valid=0. a_mn, a_m1n, a_m1n1, a_mn1 and w_sum are all 0. State is IDLE and the counter is 0.
- Reset while in CALC or DONE: outputs return to their reset values asynchronously. The partial result is discarded, and no out_valid is produced for that input.
- Latency, counted from the input handshake at edge E0:
  - PARALLEL=1: out_valid is high after E1.
  - PARALLEL=0: out_valid is high after E4.
- Back-to-back operation:
  - After an output handshake at edge Ek, in_ready is high after Ek.
  - The earliest next input handshake is at Ek+1.
  - Peak throughput is one result every 3 cycles (PARALLEL=1) or every 6 cycles (PARALLEL=0).
- Backpressure: if out_ready is low, the block stays in DONE indefinitely with outputs frozen.
- in_ready depends only on state. It has no combinational path from out_ready or in_valid.
- out_valid is a registered state decode. No output has a combinational path from any input.

## Test plan
- Basic result, DW=8, both modes:
  - Stimulus: top=3, bottom=5, left=2, right=7.
  - Required: a_mn=6, a_m1n=21, a_m1n1=35, a_mn1=10, w_sum=72.
  - out_valid rises 1 cycle after acceptance (PARALLEL=1) or 4 cycles after (PARALLEL=0).
- Full-scale inputs, DW=8:
  - Stimulus: all distances 255.
  - Required: every product 65025 and w_sum=260100, with no wrap.
  - Stimulus: all distances 0.
  - Required: all outputs 0, with out_valid still asserted.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises, while driving new values on the inputs with in_valid=1.
  - Required: outputs are unchanged and in_ready=0 throughout.
  - Then raise out_ready for 1 cycle. Required: in_ready rises, and the held input is accepted on the next edge.
- Streaming:
  - Stimulus: in_valid and out_ready held at 1 for three operand sets, (1,2,3,4), (10,20,30,40), (255,1,1,255).
  - Required: three results delivered in order, spaced exactly 3 cycles apart (PARALLEL=1) or 6 cycles apart (PARALLEL=0).
  - Check the results against a reference model.
- Reset mid-operation, PARALLEL=0:
  - Stimulus: assert reset during CALC step 2.
  - Required: out_valid=0, all outputs 0, and in_ready=1 immediately (asynchronously).
  - After reset is released, a fresh input produces a correct result with no residue left in the accumulator.
- Width parameter, DW=12:
  - Stimulus: top=4095, right=4095, left=1, bottom=1.
  - Required: a_m1n=16769025, a_mn=4095, a_m1n1=4095, a_mn1=1, w_sum=16777216.

Source files
------------

// File: rtl/area_weight_gen.sv
// Bilinear area weight generator: four distance products plus their exact sum.
// Build-time choice of four parallel multipliers or one time-shared multiplier.
module area_weight_gen #(
    parameter int DW       = 8,
    parameter bit PARALLEL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   top,
    input  logic [DW-1:0]   bottom,
    input  logic [DW-1:0]   left,
    input  logic [DW-1:0]   right,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*DW-1:0] a_mn,
    output logic [2*DW-1:0] a_m1n,
    output logic [2*DW-1:0] a_m1n1,
    output logic [2*DW-1:0] a_mn1,
    output logic [2*DW+1:0] w_sum,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] op_t;
    logic [DW-1:0] op_b;
    logic [DW-1:0] op_l;
    logic [DW-1:0] op_r;
    logic [1:0]    step;

    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [PW-1:0] sh_prod;
    logic [PW-1:0] p_mn;
    logic [PW-1:0] p_m1n;
    logic [PW-1:0] p_m1n1;
    logic [PW-1:0] p_mn1;

    // Operand pair for the shared multiplier, walking the four corners in order.
    always_comb begin
        mul_a = op_l;
        mul_b = op_t;
        unique case (step)
            2'd0: begin mul_a = op_l; mul_b = op_t; end
            2'd1: begin mul_a = op_t; mul_b = op_r; end
            2'd2: begin mul_a = op_r; mul_b = op_b; end
            2'd3: begin mul_a = op_b; mul_b = op_l; end
        endcase
    end

    assign sh_prod = PW'(mul_a) * PW'(mul_b);
    assign p_mn    = PW'(op_l) * PW'(op_t);
    assign p_m1n   = PW'(op_t) * PW'(op_r);
    assign p_m1n1  = PW'(op_r) * PW'(op_b);
    assign p_mn1   = PW'(op_b) * PW'(op_l);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_t   <= '0;
            op_b   <= '0;
            op_l   <= '0;
            op_r   <= '0;
            step   <= 2'd0;
            a_mn   <= '0;
            a_m1n  <= '0;
            a_m1n1 <= '0;
            a_mn1  <= '0;
            w_sum  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_t  <= top;
                        op_b  <= bottom;
                        op_l  <= left;
                        op_r  <= right;
                        step  <= 2'd0;
                        w_sum <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (PARALLEL) begin
                        a_mn   <= p_mn;
                        a_m1n  <= p_m1n;
                        a_m1n1 <= p_m1n1;
                        a_mn1  <= p_mn1;
                        w_sum  <= SW'(p_mn) + SW'(p_m1n)
                                + SW'(p_m1n1) + SW'(p_mn1);
                        state  <= DONE;
                    end else begin
                        unique case (step)
                            2'd0: a_mn   <= sh_prod;
                            2'd1: a_m1n  <= sh_prod;
                            2'd2: a_m1n1 <= sh_prod;
                            2'd3: a_mn1  <= sh_prod;
                        endcase
                        w_sum <= w_sum + SW'(sh_prod);
                        step  <= step + 2'd1;
                        if (step == 2'd3) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
